// File: rtl/input_debounce.sv
// Multi-channel debouncer: a 2-FF synchroniser per channel, then a STABLE/PENDING FSM
// with a registered level and one-cycle rise/fall pulses. Optional macro DEBOUNCE_TICK_EN.
module input_debounce #(
    parameter int N             = 8,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         reset,
`ifdef DEBOUNCE_TICK_EN
    input  logic         tick,
`endif
    input  logic [N-1:0] din,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {STABLE, PENDING} state_t;

    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic         step;

    // The synchroniser always runs on every clock. Only the FSM is gated by tick.
`ifdef DEBOUNCE_TICK_EN
    assign step = tick;
`else
    assign step = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             change;
        logic             rise_d;
        logic             fall_d;
        logic             rise_q;
        logic             fall_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= STABLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // cnt_q holds the number of consecutive samples that differ from level_q.
        // Accept the new level on the STABLE_CYCLES-th such sample. The counter
        // stops at CNT_LAST and never wraps.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            change  = 1'b0;
            if (step) begin
                case (state_q)
                    STABLE: begin
                        cnt_d = '0;
                        if (s2[i] != level_q) begin
                            state_d = PENDING;
                            cnt_d   = CNT_ONE;
                        end
                    end
                    PENDING: begin
                        if (s2[i] == level_q) begin
                            state_d = STABLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = STABLE;
                            cnt_d   = '0;
                            level_d = s2[i];
                            change  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        always_comb begin
            rise_d = change & s2[i];
            fall_d = change & ~s2[i];
        end

        assign level[i] = level_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
    end

endmodule

// File: tb/tb_input_debounce.sv
// Randomised and directed bench for input_debounce. The reference model keeps a window
// of recent samples. It changes level when the last STABLE_CYCLES samples all differ from it.
module tb_input_debounce;

    localparam int N  = 8;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tick_sig = 1'b1;
    logic [N-1:0] din = '0;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tick_mode = 0;

    logic [N-1:0] pipe[$];
    logic [N-1:0] hist[$];
    logic [N-1:0] lvl_m  = '0;
    logic [N-1:0] rise_m = '0;
    logic [N-1:0] fall_m = '0;

    input_debounce #(.N(N), .STABLE_CYCLES(SC)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef DEBOUNCE_TICK_EN
        .tick  (tick_sig),
`endif
        .din   (din),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        pipe.delete();
        pipe.push_back('0);
        pipe.push_back('0);
        hist.delete();
        lvl_m  = '0;
        rise_m = '0;
        fall_m = '0;
    endtask

    // One clock edge. Drives tick, advances the model and returns 1 time unit after the edge.
    task automatic step();
        logic [N-1:0] samp;
        logic [N-1:0] junk;
        bit           all_diff;
        tick_sig = (tick_mode == 0) ? 1'b1 : ((tick_mode == 1) ? (cyc % 3 == 0) : 1'b0);
        @(posedge clk);
        cyc++;
        samp = pipe.pop_front();
        pipe.push_back(din);
        rise_m = '0;
        fall_m = '0;
        if (tick_sig) begin
            hist.push_back(samp);
            if (hist.size() > SC) junk = hist.pop_front();
            if (hist.size() == SC) begin
                for (int c = 0; c < N; c++) begin
                    all_diff = 1'b1;
                    foreach (hist[j]) if (hist[j][c] == lvl_m[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        lvl_m[c] = ~lvl_m[c];
                        if (lvl_m[c]) rise_m[c] = 1'b1;
                        else          fall_m[c] = 1'b1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int n;
        din = '1;
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({level, rise, fall} !== '0) begin
            bad++;
            $display("FAIL reset_immediate: got %h want 0", {level, rise, fall});
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if ({level, rise, fall} !== '0) begin
                bad++;
                $display("FAIL reset_hold: got %h want 0", {level, rise, fall});
            end
        end
        reset = 1'b0;
        model_reset();
        n = 0;
        do begin step(); n++; end while (rise === '0 && n < 20);
        total++;
        if (n !== SC + 2) begin
            bad++;
            $display("FAIL reset_latency: got %0d edges want %0d", n, SC + 2);
        end
        total++;
        if (rise !== 8'hFF || level !== 8'hFF || fall !== 8'h00) begin
            bad++;
            $display("FAIL reset_rise: got rise=%h level=%h fall=%h want FF FF 00", rise, level, fall);
        end
        step();
        total++;
        if (rise !== 8'h00 || level !== 8'hFF) begin
            bad++;
            $display("FAIL reset_pulse_width: got rise=%h level=%h want 00 FF", rise, level);
        end
        din = '0;
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({level, rise, fall} !== '0) begin
            bad++;
            $display("FAIL reset_midcount: got %h want 0", {level, rise, fall});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (8) begin
            step();
            total++;
            if ({level, rise, fall} !== '0) begin
                bad++;
                $display("FAIL reset_discard: got %h want 0", {level, rise, fall});
            end
        end
    endtask

    task automatic test_clean_step();
        int n;
        din[0] = 1'b1;
        n = 0;
        do begin step(); n++; end while (rise[0] !== 1'b1 && n < 20);
        total++;
        if (n !== SC + 2 || level[0] !== 1'b1) begin
            bad++;
            $display("FAIL clean_rise: got edges=%0d level=%b want %0d 1", n, level[0], SC + 2);
        end
        step();
        total++;
        if (rise[0] !== 1'b0 || level[0] !== 1'b1) begin
            bad++;
            $display("FAIL clean_rise_width: got rise=%b level=%b want 0 1", rise[0], level[0]);
        end
        repeat (4) step();
        din[0] = 1'b0;
        n = 0;
        do begin step(); n++; end while (fall[0] !== 1'b1 && n < 20);
        total++;
        if (n !== SC + 2 || level[0] !== 1'b0 || rise[0] !== 1'b0) begin
            bad++;
            $display("FAIL clean_fall: got edges=%0d level=%b want %0d 0", n, level[0], SC + 2);
        end
    endtask

    task automatic test_bounce();
        int n;
        logic [3:0] pat;
        repeat (6) step();
        pat = 4'b0101;
        for (int i = 3; i >= 0; i--) begin
            din[1] = pat[i] ? 1'b0 : 1'b1;
            step();
            total++;
            if ({level[1], rise[1], fall[1]} !== 3'b000) begin
                bad++;
                $display("FAIL bounce_quiet: got %b want 000", {level[1], rise[1], fall[1]});
            end
        end
        din[1] = 1'b1;
        n = 0;
        do begin step(); n++; end while (rise[1] !== 1'b1 && n < 20);
        total++;
        if (n !== SC + 2) begin
            bad++;
            $display("FAIL bounce_latency: got %0d edges want %0d", n, SC + 2);
        end
    endtask

    task automatic test_glitch();
        din[2] = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) din[2] = 1'b0;
            step();
            total++;
            if ({level[2], rise[2], fall[2]} !== 3'b000) begin
                bad++;
                $display("FAIL glitch: got %b want 000", {level[2], rise[2], fall[2]});
            end
        end
    endtask

    task automatic test_multi();
        int n;
        repeat (8) step();
        din[7:4] = 4'hF;
        n = 0;
        do begin step(); n++; end while (rise === '0 && n < 20);
        total++;
        if (rise !== 8'hF0 || fall !== 8'h00 || n !== SC + 2) begin
            bad++;
            $display("FAIL multi_rise: got rise=%h fall=%h edges=%0d want F0 00 %0d", rise, fall, n, SC + 2);
        end
        total++;
        if (level !== 8'hF2) begin
            bad++;
            $display("FAIL multi_level: got %h want F2", level);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] flip;
        for (int t = 0; t < 400; t++) begin
            flip = '0;
            for (int c = 0; c < N; c++) flip[c] = ($urandom_range(0, 5) == 0);
            din = din ^ flip;
            step();
            total++;
            if (level !== lvl_m || rise !== rise_m || fall !== fall_m) begin
                bad++;
                $display("FAIL random: got l=%h r=%h f=%h want l=%h r=%h f=%h",
                         level, rise, fall, lvl_m, rise_m, fall_m);
            end
        end
        din = '0;
        repeat (2 * SC + 4) step();
        total++;
        if (level !== 8'h00 || level !== lvl_m) begin
            bad++;
            $display("FAIL random_settle: got %h want 00", level);
        end
    endtask

`ifdef DEBOUNCE_TICK_EN
    task automatic test_tick();
        int n;
        tick_mode = 1;
        din[3] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            total++;
            if (level !== lvl_m || rise !== rise_m) begin
                bad++;
                $display("FAIL tick_track: got l=%h r=%h want l=%h r=%h", level, rise, lvl_m, rise_m);
            end
        end while (rise[3] !== 1'b1 && n < 60);
        total++;
        if (level[3] !== 1'b1 || n < 3 * (SC - 1)) begin
            bad++;
            $display("FAIL tick_rise: got level=%b edges=%0d want 1 >=%0d", level[3], n, 3 * (SC - 1));
        end
        step();
        total++;
        if (rise[3] !== 1'b0) begin
            bad++;
            $display("FAIL tick_width: got %b want 0", rise[3]);
        end
        tick_mode = 2;
        din[3] = 1'b0;
        repeat (20) begin
            step();
            total++;
            if (level[3] !== 1'b1 || fall[3] !== 1'b0) begin
                bad++;
                $display("FAIL tick_hold: got level=%b fall=%b want 1 0", level[3], fall[3]);
            end
        end
        tick_mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_multi();
        test_random();
`ifdef DEBOUNCE_TICK_EN
        test_tick();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
